// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the D-cache line port and slow memory.
// Buffers writebacks, forwards buffered lines on read hits, drains when memory is idle.
module dcache_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 28,
    parameter int DW    = 128
) (
    input  logic                       clk,
    input  logic                       proc_reset,
    input  logic                       c_read,
    input  logic                       c_write,
    input  logic [AW-1:0]              c_addr,
    input  logic [DW-1:0]              c_wdata,
    output logic [DW-1:0]              c_rdata,
    output logic                       c_ready,
    output logic                       m_read,
    output logic                       m_write,
    output logic [AW-1:0]              m_addr,
    output logic [DW-1:0]              m_wdata,
    input  logic [DW-1:0]              m_rdata,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     buf_count
);
    // state   | meaning
    // M_IDLE  | no memory transaction outstanding
    // M_READ  | read miss issued, waiting for m_ready
    // M_WRITE | head entry being written back, waiting for m_ready

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE} mstate_t;

    mstate_t         mstate_q, mstate_d;
    logic            valid_q [DEPTH];
    logic            valid_d [DEPTH];
    logic [AW-1:0]   addr_q  [DEPTH];
    logic [AW-1:0]   addr_d  [DEPTH];
    logic [DW-1:0]   data_q  [DEPTH];
    logic [DW-1:0]   data_d  [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pend_rd_q, pend_rd_d;
    logic [AW-1:0]   pend_addr_q, pend_addr_d;
    logic            c_ready_q, c_ready_d;
    logic [DW-1:0]   c_rdata_q, c_rdata_d;
    logic            m_read_q, m_read_d;
    logic            m_write_q, m_write_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_wdata_q, m_wdata_d;

    logic            hit, hit_inflight, sample, enq, pop;
    logic [PW-1:0]   hit_idx;

    always_comb begin
        mstate_d    = mstate_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        pend_rd_d   = pend_rd_q;
        pend_addr_d = pend_addr_q;
        c_ready_d   = 1'b0;
        c_rdata_d   = c_rdata_q;
        m_read_d    = m_read_q;
        m_write_d   = m_write_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        enq         = 1'b0;
        pop         = 1'b0;
        hit         = 1'b0;
        hit_idx     = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == c_addr) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
        hit_inflight = hit && (mstate_q == M_WRITE) && (hit_idx == head_q);
        sample       = !c_ready_q && !pend_rd_q;

        if (sample && c_write) begin
            if (hit && !hit_inflight) begin
                data_d[hit_idx] = c_wdata;
                c_ready_d       = 1'b1;
            end else if (!hit && count_q != CW'(DEPTH)) begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = c_addr;
                data_d[tail_q]  = c_wdata;
                tail_d          = tail_q + PW'(1);
                enq             = 1'b1;
                c_ready_d       = 1'b1;
            end
        end else if (sample && c_read) begin
            if (hit) begin
                c_rdata_d = data_q[hit_idx];
                c_ready_d = 1'b1;
            end else begin
                pend_rd_d   = 1'b1;
                pend_addr_d = c_addr;
            end
        end

        case (mstate_q)
            M_IDLE: begin
                if (pend_rd_q) begin
                    mstate_d = M_READ;
                    m_read_d = 1'b1;
                    m_addr_d = pend_addr_q;
                end else if (count_q != '0) begin
                    // Issue from next-state data so a coalesce on this edge is not lost
                    mstate_d  = M_WRITE;
                    m_write_d = 1'b1;
                    m_addr_d  = addr_q[head_q];
                    m_wdata_d = data_d[head_q];
                end
            end
            M_READ: begin
                if (m_ready) begin
                    mstate_d  = M_IDLE;
                    m_read_d  = 1'b0;
                    pend_rd_d = 1'b0;
                    c_rdata_d = m_rdata;
                    c_ready_d = 1'b1;
                end
            end
            M_WRITE: begin
                if (m_ready) begin
                    mstate_d        = M_IDLE;
                    m_write_d       = 1'b0;
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PW'(1);
                    pop             = 1'b1;
                end
            end
            default: mstate_d = M_IDLE;
        endcase

        count_d = count_q + CW'(enq) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            mstate_q    <= M_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            pend_rd_q   <= 1'b0;
            pend_addr_q <= '0;
            c_ready_q   <= 1'b0;
            c_rdata_q   <= '0;
            m_read_q    <= 1'b0;
            m_write_q   <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
        end else begin
            mstate_q    <= mstate_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            pend_rd_q   <= pend_rd_d;
            pend_addr_q <= pend_addr_d;
            c_ready_q   <= c_ready_d;
            c_rdata_q   <= c_rdata_d;
            m_read_q    <= m_read_d;
            m_write_q   <= m_write_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            valid_q     <= valid_d;
        end
    end

    // Entry payload needs no reset: it is only observed through valid_q
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign c_ready   = c_ready_q;
    assign c_rdata   = c_rdata_q;
    assign m_read    = m_read_q;
    assign m_write   = m_write_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign buf_count = count_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a latency-configurable slow memory
// model and a golden line store.
module tb_dcache_write_buffer;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         c_read, c_write;
    logic [27:0]  c_addr;
    logic [127:0] c_wdata, c_rdata;
    logic         c_ready;
    logic         m_read, m_write;
    logic [27:0]  m_addr;
    logic [127:0] m_wdata, m_rdata;
    logic         m_ready;
    logic [2:0]   buf_count;

    dcache_write_buffer #(.DEPTH(4), .AW(28), .DW(128)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [127:0] mem  [logic [27:0]];
    logic [127:0] gold [logic [27:0]];
    logic         log_wr   [$];
    logic [27:0]  log_addr [$];
    int           mem_lat   = 1;
    logic         mem_stall = 1'b0;
    logic         seen_mread = 1'b0;
    logic         both_err   = 1'b0;

    function automatic logic [127:0] dflt(input logic [27:0] a);
        return {4{4'hD, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slow memory: acknowledges after mem_lat active cycles unless stalled
    initial begin : memory_model
        int cnt;
        cnt = 0;
        m_ready = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            m_ready = 1'b0;
            if (m_read && m_write) both_err = 1'b1;
            if (m_read) seen_mread = 1'b1;
            if (proc_reset || !(m_read || m_write)) begin
                cnt = 0;
            end else if (!mem_stall) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    cnt = 0;
                    m_ready = 1'b1;
                    log_wr.push_back(m_write);
                    log_addr.push_back(m_addr);
                    if (m_write) mem[m_addr] = m_wdata;
                    else m_rdata = mem.exists(m_addr) ? mem[m_addr] : dflt(m_addr);
                end
            end
        end
    end

    task automatic do_write(input logic [27:0] a, input logic [127:0] d, output int cyc);
        @(negedge clk);
        c_write = 1'b1; c_addr = a; c_wdata = d;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!c_ready && cyc < 300);
        chk("wr_done", c_ready, 1);
        gold[a] = d;
        @(negedge clk);
        c_write = 1'b0;
    endtask

    task automatic do_read(input logic [27:0] a, output logic [127:0] d, output int cyc);
        @(negedge clk);
        c_read = 1'b1; c_addr = a;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!c_ready && cyc < 300);
        chk("rd_done", c_ready, 1);
        d = c_rdata;
        @(negedge clk);
        c_read = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((buf_count != 0 || m_write || m_read) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", {buf_count, m_write, m_read}, 0);
    endtask

    logic [127:0] rd, exp_d;
    int cyc;
    logic [27:0] ra;

    initial begin
        proc_reset = 1'b1;
        c_read = 1'b0; c_write = 1'b0; c_addr = '0; c_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); proc_reset = 1'b0;

        // 1: reset in the middle of a write and an outstanding drain
        mem_stall = 1'b1;
        do_write(28'h99, 128'h99, cyc);
        @(posedge clk); #1;
        chk("pre_rst_mwrite", m_write, 1);
        @(negedge clk);
        proc_reset = 1'b1; c_write = 1'b1; c_addr = 28'h77; c_wdata = 128'h77;
        @(posedge clk); #1;
        chk("rst_c_ready", c_ready, 0);
        chk("rst_c_rdata", c_rdata, 0);
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_count", buf_count, 0);
        @(negedge clk);
        proc_reset = 1'b0; c_write = 1'b0;
        gold.delete(28'h99);
        repeat (3) @(posedge clk); #1;
        chk("post_rst_count", buf_count, 0);
        chk("post_rst_mwrite", m_write, 0);

        // 2: posted write, memory stalled
        do_write(28'h10, 128'hA, cyc);
        chk("post_lat", cyc, 1);
        chk("post_count", buf_count, 1);
        @(negedge clk);
        @(posedge clk); #1;
        chk("post_mwrite", m_write, 1);
        chk("post_maddr", m_addr, 28'h10);
        chk("post_mwdata", m_wdata, 128'hA);
        mem_stall = 1'b0;
        wait_drain();
        chk("post_mem", mem[28'h10], 128'hA);

        // 3: forwarding from the buffer
        mem_stall = 1'b1; seen_mread = 1'b0;
        do_write(28'h20, 128'hB, cyc);
        do_read(28'h20, rd, cyc);
        chk("fwd_data", rd, 128'hB);
        chk("fwd_lat", cyc, 1);
        chk("fwd_no_mread", seen_mread, 0);
        mem_stall = 1'b0;
        wait_drain();

        // 4: read miss arriving mid-drain takes priority over remaining writes
        mem_lat = 10;
        log_wr.delete(); log_addr.delete();
        do_write(28'h100, 128'h100, cyc);
        do_write(28'h110, 128'h110, cyc);
        do_write(28'h120, 128'h120, cyc);
        do_read(28'h40, rd, cyc);
        chk("miss_data", rd, dflt(28'h40));
        wait_drain();
        chk("order_len", log_wr.size(), 4);
        if (log_wr.size() == 4) begin
            chk("order0", {log_wr[0], log_addr[0]}, {1'b1, 28'h100});
            chk("order1", {log_wr[1], log_addr[1]}, {1'b0, 28'h40});
            chk("order2", {log_wr[2], log_addr[2]}, {1'b1, 28'h110});
            chk("order3", {log_wr[3], log_addr[3]}, {1'b1, 28'h120});
        end

        // 5: full buffer, coalesce, and stall until the first pop
        mem_lat = 1; mem_stall = 1'b1;
        for (int i = 1; i <= 4; i++) do_write(28'(i), 128'(i) + 128'hF00, cyc);
        chk("full_count", buf_count, 4);
        do_write(28'h2, 128'hC, cyc);
        chk("coal_lat", cyc, 1);
        chk("coal_count", buf_count, 4);
        fork
            do_write(28'h5, 128'h5, cyc);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_no_ready", c_ready, 0);
                chk("stall_count", buf_count, 4);
                @(negedge clk); mem_stall = 1'b0;
            end
        join
        chk("stall_lat", cyc > 6, 1);
        wait_drain();
        chk("coal_mem", mem[28'h2], 128'hC);
        chk("stall_mem", mem[28'h5], 128'h5);

        // 6: random mixed traffic against the golden store
        mem_lat = 3;
        for (int k = 0; k < 40; k++) begin
            ra = 28'h200 + 28'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, {$urandom, $urandom, $urandom, $urandom}, cyc);
            end else begin
                exp_d = gold.exists(ra) ? gold[ra] : dflt(ra);
                do_read(ra, rd, cyc);
                chk("rand_read", rd, exp_d);
            end
        end
        wait_drain();
        for (int j = 0; j < 6; j++) begin
            ra = 28'h200 + 28'(j);
            if (gold.exists(ra)) chk("rand_mem", mem.exists(ra) ? mem[ra] : dflt(ra), gold[ra]);
        end
        chk("no_rw_overlap", both_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
